// File: rtl/ring_follower_if.sv
// Observation bus for ring_follower: the sampled ring plus the decoded status.
// The monitor side (master) drives en/ring_in; the follower (slave) returns the status.
interface ring_follower_if #(
    parameter int WIDTH = 3,
    parameter int ERR_W = 8
);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic             en;
    logic [WIDTH-1:0] ring_in;
    logic [IDX_W-1:0] idx;
    logic             valid;
    logic             locked;
    logic             err_pulse;
    logic             wrap_pulse;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output en, ring_in,
        input  idx, valid, locked, err_pulse, wrap_pulse, err_cnt
    );

    modport slave (
        input  en, ring_in,
        output idx, valid, locked, err_pulse, wrap_pulse, err_cnt
    );
endinterface

// File: rtl/ring_follower.sv
// One-hot ring counter follower: decodes, checks rotation order, runs a lock FSM.
// Optional macro RING_FOLLOWER_STALL_TOL_EN makes a repeated sample a legal stall.
module ring_follower #(
    parameter int WIDTH    = 3,
    parameter int LOCK_CNT = 2,
    parameter int ERR_W    = 8
) (
    input  logic          clk,
    input  logic          rst,
    ring_follower_if.slave rf
);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int GC_W  = $clog2(LOCK_CNT + 1);

    typedef enum logic [1:0] {IDLE, SEARCH, LOCKED} state_t;

    state_t           state, state_n;
    logic [GC_W-1:0]  good, good_n, good_inc;
    logic [WIDTH-1:0] prev, rot_prev;
    logic [IDX_W-1:0] idx_q, dec_idx;
    logic             valid_q, locked_q, errp_q, wrap_q;
    logic             errp_n, wrap_n;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_n;
    logic             onehot, match, stall;
    int               hot_cnt;

    assign rot_prev = {prev[WIDTH-2:0], prev[WIDTH-1]};

    always_comb begin
        hot_cnt = 0;
        dec_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (rf.ring_in[i]) begin
                hot_cnt = hot_cnt + 1;
                dec_idx = IDX_W'(i);
            end
        end
    end

    assign onehot   = (hot_cnt == 1);
    assign match    = onehot && (rf.ring_in == rot_prev);
    assign good_inc = (good == GC_W'(LOCK_CNT)) ? good : good + 1'b1;

`ifdef RING_FOLLOWER_STALL_TOL_EN
    assign stall = onehot && (rf.ring_in == prev);
`else
    assign stall = 1'b0;
`endif

    always_comb begin
        state_n   = state;
        good_n    = good;
        errp_n    = 1'b0;
        wrap_n    = 1'b0;
        err_cnt_n = err_cnt_q;
        unique case (state)
            IDLE: begin
                if (onehot) begin
                    state_n = SEARCH;
                    good_n  = '0;
                end
            end
            SEARCH: begin
                if (stall) begin
                    state_n = SEARCH;
                end else if (match) begin
                    good_n = good_inc;
                    if (good_inc == GC_W'(LOCK_CNT))
                        state_n = LOCKED;
                end else if (onehot) begin
                    good_n = '0;
                end else begin
                    state_n = IDLE;
                    good_n  = '0;
                end
            end
            LOCKED: begin
                if (stall) begin
                    state_n = LOCKED;
                end else if (match) begin
                    good_n = good_inc;
                    wrap_n = (dec_idx == '0) && (idx_q == IDX_W'(WIDTH - 1));
                end else begin
                    // Any break drops lock; a still-legal sample lets us re-acquire from SEARCH.
                    errp_n  = 1'b1;
                    good_n  = '0;
                    state_n = onehot ? SEARCH : IDLE;
                    if (!(&err_cnt_q))
                        err_cnt_n = err_cnt_q + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                good_n  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            good      <= '0;
            prev      <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            errp_q    <= 1'b0;
            wrap_q    <= 1'b0;
            err_cnt_q <= '0;
        end else if (rf.en) begin
            state     <= state_n;
            good      <= good_n;
            valid_q   <= onehot;
            locked_q  <= (state_n == LOCKED);
            errp_q    <= errp_n;
            wrap_q    <= wrap_n;
            err_cnt_q <= err_cnt_n;
            if (onehot) begin
                prev  <= rf.ring_in;
                idx_q <= dec_idx;
            end
        end else begin
            errp_q <= 1'b0;
            wrap_q <= 1'b0;
        end
    end

    assign rf.idx        = idx_q;
    assign rf.valid      = valid_q;
    assign rf.locked     = locked_q;
    assign rf.err_pulse  = errp_q;
    assign rf.wrap_pulse = wrap_q;
    assign rf.err_cnt    = err_cnt_q;
endmodule

// File: tb/tb_ring_follower.sv
// Scoreboard bench for ring_follower (WIDTH=3, LOCK_CNT=2, ERR_W=2).
module tb_ring_follower;
`ifdef RING_FOLLOWER_STALL_TOL_EN
    localparam bit STALL = 1'b1;
`else
    localparam bit STALL = 1'b0;
`endif

    typedef struct packed {
        logic [1:0] idx;
        logic       valid;
        logic       locked;
        logic       ep;
        logic       wp;
        logic [1:0] ec;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   vec_no  = 0;
    obs_t sb[$];
    obs_t m_exp, m_act;

    ring_follower_if #(.WIDTH(3), .ERR_W(2)) rf ();

    ring_follower #(.WIDTH(3), .LOCK_CNT(2), .ERR_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .rf  (rf.slave)
    );

    always #5 clk = ~clk;

    function automatic obs_t observe();
        obs_t o;
        o.idx = rf.idx; o.valid = rf.valid; o.locked = rf.locked;
        o.ep = rf.err_pulse; o.wp = rf.wrap_pulse; o.ec = rf.err_cnt;
        return o;
    endfunction

    task automatic report(input string name, input obs_t act, input obs_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got idx=%0d v=%b l=%b ep=%b wp=%b ec=%0d, want idx=%0d v=%b l=%b ep=%b wp=%b ec=%0d",
                     name, act.idx, act.valid, act.locked, act.ep, act.wp, act.ec,
                     exp.idx, exp.valid, exp.locked, exp.ep, exp.wp, exp.ec);
        end
    endtask

    // Drive one sample on the falling edge and queue what the next rising edge must produce.
    task automatic step(input logic e, input logic [2:0] r, input logic [1:0] i, input logic v,
                        input logic l, input logic ep, input logic wp, input logic [1:0] ec);
        obs_t x;
        @(negedge clk);
        rf.en = e;
        rf.ring_in = r;
        x.idx = i; x.valid = v; x.locked = l; x.ep = ep; x.wp = wp; x.ec = ec;
        sb.push_back(x);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                m_exp = sb.pop_front();
                m_act = observe();
                vec_no++;
                report($sformatf("vec%0d", vec_no), m_act, m_exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        rf.en = 1'b1;
        rf.ring_in = 3'b001;
        // Held in reset with live stimulus: everything stays zero.
        for (int k = 0; k < 3; k++)
            step(1'b1, 3'($urandom_range(0, 7)), 2'd0, 0, 0, 0, 0, 2'd0);
        step(1'b0, 3'b010, 2'd0, 0, 0, 0, 0, 2'd0);
        rst = 1'b1;

        // Lock sequence with wrap
        step(1, 3'b001, 2'd0, 1, 0, 0, 0, 2'd0);
        step(1, 3'b010, 2'd1, 1, 0, 0, 0, 2'd0);
        step(1, 3'b100, 2'd2, 1, 1, 0, 0, 2'd0);
        step(1, 3'b001, 2'd0, 1, 1, 0, 1, 2'd0);
        step(1, 3'b010, 2'd1, 1, 1, 0, 0, 2'd0);
        // Break while locked, then relock from SEARCH
        step(1, 3'b001, 2'd0, 1, 0, 1, 0, 2'd1);
        step(1, 3'b010, 2'd1, 1, 0, 0, 0, 2'd1);
        step(1, 3'b100, 2'd2, 1, 1, 0, 0, 2'd1);
        // Illegal samples
        step(1, 3'b000, 2'd2, 0, 0, 1, 0, 2'd2);
        step(1, 3'b011, 2'd2, 0, 0, 0, 0, 2'd2);
        // Enable gating: nothing moves
        step(0, 3'b001, 2'd2, 0, 0, 0, 0, 2'd2);
        step(0, 3'b010, 2'd2, 0, 0, 0, 0, 2'd2);
        step(0, 3'b100, 2'd2, 0, 0, 0, 0, 2'd2);
        step(0, 3'b111, 2'd2, 0, 0, 0, 0, 2'd2);
        step(0, 3'b000, 2'd2, 0, 0, 0, 0, 2'd2);
        // Relock from IDLE, wrap, then en=0 clears the wrap pulse
        step(1, 3'b001, 2'd0, 1, 0, 0, 0, 2'd2);
        step(1, 3'b010, 2'd1, 1, 0, 0, 0, 2'd2);
        step(1, 3'b100, 2'd2, 1, 1, 0, 0, 2'd2);
        step(1, 3'b001, 2'd0, 1, 1, 0, 1, 2'd2);
        step(0, 3'b010, 2'd0, 1, 1, 0, 0, 2'd2);
        step(1, 3'b010, 2'd1, 1, 1, 0, 0, 2'd2);
        // Repeated sample while locked: error, or stall when tolerated
        step(1, 3'b010, 2'd1, 1, STALL, !STALL, 0, STALL ? 2'd2 : 2'd3);
        step(1, 3'b100, 2'd2, 1, STALL, 0, 0, STALL ? 2'd2 : 2'd3);
        step(1, 3'b001, 2'd0, 1, 1, 0, STALL, STALL ? 2'd2 : 2'd3);

        // Asynchronous reset mid-cycle while locked
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        report("async_rst", observe(), obs_t'(8'h00));
        step(1, 3'b100, 2'd0, 0, 0, 0, 0, 2'd0);
        step(0, 3'b001, 2'd0, 0, 0, 0, 0, 2'd0);
        rst = 1'b1;

        // Saturation: five lock/break cycles, err_cnt 1,2,3,3,3
        step(1, 3'b001, 2'd0, 1, 0, 0, 0, 2'd0);
        step(1, 3'b010, 2'd1, 1, 0, 0, 0, 2'd0);
        step(1, 3'b100, 2'd2, 1, 1, 0, 0, 2'd0);
        step(1, 3'b010, 2'd1, 1, 0, 1, 0, 2'd1);
        step(1, 3'b100, 2'd2, 1, 0, 0, 0, 2'd1);
        step(1, 3'b001, 2'd0, 1, 1, 0, 0, 2'd1);
        step(1, 3'b100, 2'd2, 1, 0, 1, 0, 2'd2);
        step(1, 3'b001, 2'd0, 1, 0, 0, 0, 2'd2);
        step(1, 3'b010, 2'd1, 1, 1, 0, 0, 2'd2);
        step(1, 3'b001, 2'd0, 1, 0, 1, 0, 2'd3);
        step(1, 3'b010, 2'd1, 1, 0, 0, 0, 2'd3);
        step(1, 3'b100, 2'd2, 1, 1, 0, 0, 2'd3);
        step(1, 3'b010, 2'd1, 1, 0, 1, 0, 2'd3);
        step(1, 3'b100, 2'd2, 1, 0, 0, 0, 2'd3);
        step(1, 3'b001, 2'd0, 1, 1, 0, 0, 2'd3);
        step(1, 3'b100, 2'd2, 1, 0, 1, 0, 2'd3);

        repeat (4) @(posedge clk);
        #2;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected samples never checked, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
